// File: rtl/spi_led_slave_if.sv
// -----------------------------------------------------------------------------
// spi_led_slave_if
//
// Purpose:
//   Bundles the four wires of the runner SPI link so the master side (the
//   runner controller or a testbench) and the LED slave share one definition.
//
// Signals:
//   cs    chip select, active low, driven by the master
//   sclk  SPI clock, idle low (mode 0), driven by the master
//   mosi  serial data master -> slave, LSB first
//   miso  serial readback slave -> master
//
// Modports:
//   master  drives cs/sclk/mosi, observes miso
//   slave   observes cs/sclk/mosi, drives miso
// -----------------------------------------------------------------------------
interface spi_led_slave_if;
    logic cs;
    logic sclk;
    logic mosi;
    logic miso;

    modport master (
        output cs,
        output sclk,
        output mosi,
        input  miso
    );

    modport slave (
        input  cs,
        input  sclk,
        input  mosi,
        output miso
    );
endinterface : spi_led_slave_if

// File: rtl/spi_led_slave.sv
// -----------------------------------------------------------------------------
// spi_led_slave
//
// Purpose:
//   SPI mode-0 slave that receives 8-bit LSB-first command frames and drives
//   the 6-LED runner display. The SPI wires are asynchronous to sys_clk; they
//   are synchronized, edge-detected and processed by a small IDLE/RECV/COMMIT
//   state machine. A frame is committed only when exactly REG_WIDTH sclk
//   rising edges were seen between cs falling and cs rising.
//
//   Command byte: bits [7:6] select the operation, bits [5:0] are data.
//     00 : led <= data
//     01 : led <= rotate-left-by-1(led)   (msb wraps to lsb)
//     10 : led <= rotate-right-by-1(led)  (lsb wraps to msb)
//     11 : led <= 0
//
// Optional build macro:
//   SPI_READBACK_EN  When defined, {2'b00, led} is captured at the start of
//                    each frame and shifted out on miso LSB first (bit 0
//                    immediately, one more bit per sclk falling edge, then 0).
//                    When undefined, miso is tied low and no readback
//                    register exists.
//
// Ports:
//   sys_clk     system clock
//   rstn        asynchronous active-low reset
//   spi         SPI link (slave modport): cs, sclk, mosi in; miso out
//   led         LED pattern, resets to 6'b000001
//   frame_done  one-cycle pulse when a valid frame has been applied to led
//   frame_err   one-cycle pulse when a malformed frame has been dropped
//
// Timing:
//   led and the frame_done/frame_err pulse change SYNC_STAGES+2 sys_clk
//   cycles after the raw cs rising edge. sclk high and low phases must each
//   last at least 3 sys_clk periods so every edge is seen.
// -----------------------------------------------------------------------------
module spi_led_slave #(
    parameter int LED_WIDTH   = 6,
    parameter int REG_WIDTH   = 8,   // must equal LED_WIDTH + 2
    parameter int SYNC_STAGES = 2    // minimum 2
) (
    input  logic                 sys_clk,
    input  logic                 rstn,
    spi_led_slave_if.slave       spi,
    output logic [LED_WIDTH-1:0] led,
    output logic                 frame_done,
    output logic                 frame_err
);

    // Counter must reach REG_WIDTH+1 so that "too many bits" is distinguishable
    // from a complete frame.
    localparam int CNT_W = $clog2(REG_WIDTH + 2);
    localparam int IDX_W = $clog2(REG_WIDTH);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(REG_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(REG_WIDTH + 1);

    localparam logic [LED_WIDTH-1:0] LED_RESET = LED_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'b00,
        CMD_ROL  = 2'b01,
        CMD_ROR  = 2'b10,
        CMD_CLR  = 2'b11
    } cmd_t;

    // -------------------------------------------------------------------------
    // Input synchronizers and edge detection
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_d;
    logic                   sclk_d;

    logic cs_s;
    logic sclk_s;
    logic mosi_s;

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // NOTE: synchronizers reset to the idle bus levels (cs high, sclk low) so
    // that leaving reset never manufactures a false cs or sclk edge.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b0;
        end else begin
            // NOTE: every register here uses <=, so each stage samples the
            // value its neighbour held before this edge and the chain really
            // is SYNC_STAGES flops deep.
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   spi.cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
        end
    end

    logic cs_fall;
    logic cs_rise;
    logic sclk_rise;
    logic sclk_fall;

    assign cs_fall   =  cs_d   & ~cs_s;
    assign cs_rise   = ~cs_d   &  cs_s;
    assign sclk_rise = ~sclk_d &  sclk_s;
    assign sclk_fall =  sclk_d & ~sclk_s;

    // -------------------------------------------------------------------------
    // Command decode
    // -------------------------------------------------------------------------
    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [REG_WIDTH-1:0] shreg;
    logic                 start_pend;
    logic [LED_WIDTH-1:0] led_next;
    cmd_t                 cmd;

    assign cmd = cmd_t'(shreg[REG_WIDTH-1 -: 2]);

    always_comb begin
        // NOTE: led_next gets a default before the case so no path leaves it
        // unassigned and no latch is inferred.
        led_next = led;
        unique case (cmd)
            CMD_LOAD: led_next = shreg[LED_WIDTH-1:0];
            CMD_ROL:  led_next = {led[LED_WIDTH-2:0], led[LED_WIDTH-1]};
            CMD_ROR:  led_next = {led[0], led[LED_WIDTH-1:1]};
            CMD_CLR:  led_next = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Readback path
    // -------------------------------------------------------------------------
`ifdef SPI_READBACK_EN
    // rb_rem holds the bits still to be shifted out after the one on miso.
    logic [REG_WIDTH-1:0] rb_rem;
    logic                 miso_q;

    assign spi.miso = miso_q;
`else
    assign spi.miso = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Frame state machine
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            start_pend <= 1'b0;
            led        <= LED_RESET;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
`ifdef SPI_READBACK_EN
            rb_rem     <= '0;
            miso_q     <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    // A cs fall seen during COMMIT arrives here as start_pend.
                    if (cs_fall || start_pend) begin
                        state      <= RECV;
                        cnt        <= '0;
                        shreg      <= '0;
                        start_pend <= 1'b0;
`ifdef SPI_READBACK_EN
                        miso_q     <= led[0];
                        rb_rem     <= REG_WIDTH'({{(REG_WIDTH-LED_WIDTH){1'b0}}, led} >> 1);
`endif
                    end
                end

                RECV: begin
                    if (cs_rise) begin
                        state <= COMMIT;
`ifdef SPI_READBACK_EN
                        miso_q <= 1'b0;
                        rb_rem <= '0;
`endif
                    end else begin
                        if (sclk_rise) begin
                            if (cnt < CNT_FULL) begin
                                shreg[cnt[IDX_W-1:0]] <= mosi_s;
                            end
                            if (cnt < CNT_SAT) begin
                                cnt <= cnt + 1'b1;
                            end
                        end
`ifdef SPI_READBACK_EN
                        // Once rb_rem has emptied, zeros shift in and miso holds 0.
                        if (sclk_fall) begin
                            miso_q <= rb_rem[0];
                            rb_rem <= rb_rem >> 1;
                        end
`endif
                    end
                end

                COMMIT: begin
                    state      <= IDLE;
                    start_pend <= cs_fall;
                    if (cnt == CNT_FULL) begin
                        led        <= led_next;
                        frame_done <= 1'b1;
                    end else begin
                        frame_err  <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifndef SPI_READBACK_EN
    // Falling sclk edges only matter for readback.
    logic unused_ok;
    assign unused_ok = sclk_fall;
`endif

endmodule : spi_led_slave

// File: tb/tb_spi_led_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_led_slave
//
// Drives SPI frames into spi_led_slave and compares led, the done/error
// pulses, commit latency and miso readback against a behavioural model that
// applies each command with integer arithmetic.
// -----------------------------------------------------------------------------
module tb_spi_led_slave;

    logic       sys_clk = 1'b0;
    logic       rstn;
    logic [5:0] led;
    logic       frame_done;
    logic       frame_err;

    spi_led_slave_if spi ();

    spi_led_slave dut (
        .sys_clk    (sys_clk),
        .rstn       (rstn),
        .spi        (spi),
        .led        (led),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec    = 0;
    int n_miss   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    logic [5:0] exp_led;

    // Pulse counters, sampled away from the rising edge.
    always @(negedge sys_clk) begin
        if (rstn) begin
            if (frame_done) done_cnt++;
            if (frame_err)  err_cnt++;
            if (frame_done && frame_err) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Expected LED state after one frame, from the command rules.
    function automatic logic [5:0] model(input logic [5:0] cur, input logic [7:0] f, input int nbits);
        int v;
        v = int'(cur);
        if (nbits != 8) return cur;
        case (f[7:6])
            2'd0:    v = int'(f[5:0]);
            2'd1:    v = (v * 2 + v / 32) % 64;
            2'd2:    v = v / 2 + (v % 2) * 32;
            default: v = 0;
        endcase
        return 6'(v);
    endfunction

    task automatic run_frame(input logic [7:0] data, input int nbits, input string tag);
        logic [7:0] rb;
        logic [7:0] exp_rb;
        logic [7:0] full;
        int         d0, e0, k;
        bit         seen;

        full   = {2'b00, exp_led};
        exp_rb = '0;
        rb     = '0;
        d0     = done_cnt;
        e0     = err_cnt;

        spi.cs = 1'b0;
        step(8);
        for (int i = 0; i < nbits; i++) begin
            spi.mosi = (i < 8) ? data[i] : 1'($urandom);
            step(4);
            spi.sclk = 1'b1;
            if (i < 8) begin
                rb[i] = spi.miso;
`ifdef SPI_READBACK_EN
                exp_rb[i] = full[i];
`endif
            end
            step(8);
            spi.sclk = 1'b0;
            step(4);
        end
        check({tag, " miso"}, 32'(rb), 32'(exp_rb));

        spi.cs = 1'b1;
        k      = 0;
        seen   = 1'b0;
        while (!seen && k < 30) begin
            @(posedge sys_clk);
            k++;
            @(negedge sys_clk);
            if (frame_done || frame_err) seen = 1'b1;
        end
        check({tag, " latency"}, seen ? 32'(k) : 32'd99, 32'd4);
        step(6);

        exp_led = model(exp_led, data, nbits);
        check({tag, " led"},  32'(led), 32'(exp_led));
        check({tag, " done"}, 32'(done_cnt - d0), (nbits == 8) ? 32'd1 : 32'd0);
        check({tag, " err"},  32'(err_cnt - e0),  (nbits == 8) ? 32'd0 : 32'd1);
        check({tag, " miso idle"}, 32'(spi.miso), 32'd0);
    endtask

    initial begin
        int d0, e0, nb;
        logic [7:0] f;

        spi.cs   = 1'b1;
        spi.sclk = 1'b0;
        spi.mosi = 1'b0;
        rstn     = 1'b0;
        exp_led  = 6'b000001;

        // Reset state
        step(5);
        rstn = 1'b1;
        step(5);
        check("reset led",  32'(led),        32'h01);
        check("reset miso", 32'(spi.miso),   32'd0);
        check("reset done", 32'(done_cnt),   32'd0);
        check("reset err",  32'(err_cnt),    32'd0);

        // sclk toggles with cs high are ignored
        for (int i = 0; i < 10; i++) begin
            spi.sclk = 1'b1; step(4); spi.sclk = 1'b0; step(4);
        end
        check("idle sclk led",   32'(led),                32'h01);
        check("idle sclk pulse", 32'(done_cnt + err_cnt), 32'd0);

        // Directed command sequence
        run_frame(8'b0010_1010, 8, "load 101010");
        run_frame(8'b0100_0000, 8, "rol");
        run_frame(8'b1000_0000, 8, "ror");
        run_frame(8'b1100_0000 | 8'($urandom_range(0, 63)), 8, "clear");

        // Malformed frames
        run_frame(8'b0011_1111, 5, "short 5");
        run_frame(8'b0011_1111, 9, "long 9");
        run_frame(8'b0011_1111, 0, "empty");

        // Readback of 110011
        run_frame(8'b0011_0011, 8, "load 110011");
        run_frame(8'($urandom), 8, "readback");

        // Reset in the middle of a frame
        spi.cs = 1'b0;
        step(8);
        for (int i = 0; i < 4; i++) begin
            spi.mosi = 1'b1; step(4); spi.sclk = 1'b1; step(8); spi.sclk = 1'b0; step(4);
        end
        rstn = 1'b0;
        #1;
        check("abort led",  32'(led),        32'h01);
        check("abort done", 32'(frame_done), 32'd0);
        check("abort err",  32'(frame_err),  32'd0);
        spi.cs   = 1'b1;
        spi.sclk = 1'b0;
        step(3);
        d0 = done_cnt;
        e0 = err_cnt;
        rstn = 1'b1;
        step(20);
        check("abort pulses", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
        exp_led = 6'b000001;
        run_frame(8'b0000_0111, 8, "after abort");
        check("after abort 000111", 32'(led), 32'h07);

        // Randomized frames
        for (int n = 0; n < 40; n++) begin
            f  = 8'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : 8;
            run_frame(f, nb, $sformatf("rand%0d", n));
        end

        check("never both", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_spi_led_slave
